// File: rtl/gf8_reduce_acc.sv
// gf8_reduce_acc: reduces 15-bit carry-less products modulo POLY and either
// emits each reduced value alone or XOR-accumulates a frame of them into one
// GF(2^8) result with a saturating term count.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   p[14:0]             carry-less product, bit i = coefficient of x^i
//   p_valid / p_ready   input handshake (p, p_last, acc_en qualified by p_valid)
//   p_last              last term of an accumulation frame (only with acc_en)
//   acc_en              beat joins the running sum instead of being emitted alone
//   r[7:0], r_count     reduced result and number of terms folded into it
//   r_valid / r_ready   output handshake
module gf8_reduce_acc #(
    parameter logic [8:0] POLY = 9'h11B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [14:0] p,
    input  logic        p_valid,
    output logic        p_ready,
    input  logic        p_last,
    input  logic        acc_en,
    output logic [7:0]  r,
    output logic [7:0]  r_count,
    output logic        r_valid,
    input  logic        r_ready
);

    localparam int unsigned PW = 15;
    localparam int unsigned GW = 8;
    localparam int unsigned CW = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Input stage S1
    logic          s1_valid_q, s1_valid_d;
    logic [PW-1:0] s1_p_q,     s1_p_d;
    logic          s1_last_q,  s1_last_d;
    logic          s1_acc_q,   s1_acc_d;

    // Accumulator, term counter and frame state
    logic [GW-1:0] acc_q,   acc_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    state_t        state_q, state_d;

    // Output register O
    logic          r_valid_q, r_valid_d;
    logic [GW-1:0] r_q,       r_d;
    logic [CW-1:0] r_count_q, r_count_d;

    logic          ofree;
    logic          s1_adv;
    logic          s1_emit;
    logic [PW-1:0] red_tmp;
    logic [GW-1:0] red;
    logic [CW-1:0] cnt_inc;

    // Polynomial reduction of the S1 product, clearing bits 14..8 highest first
    always_comb begin
        red_tmp = s1_p_q;
        for (int i = PW - 1; i >= GW; i--) begin
            if (red_tmp[i]) begin
                red_tmp = red_tmp ^ (PW'(POLY) << (i - GW));
            end
        end
        red = red_tmp[GW-1:0];
    end

    assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

    // Handshake: a mid-frame acc beat never needs the output slot
    assign ofree   = !r_valid_q || r_ready;
    assign s1_emit = !s1_acc_q || s1_last_q;
    assign s1_adv  = s1_valid_q && ((s1_acc_q && !s1_last_q) || ofree);
    assign p_ready = !rst && (!s1_valid_q || s1_adv);

    // Next-state for S1, accumulator FSM and output register
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_p_d     = s1_p_q;
        s1_last_d  = s1_last_q;
        s1_acc_d   = s1_acc_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        state_d    = state_q;
        r_valid_d  = r_valid_q;
        r_d        = r_q;
        r_count_d  = r_count_q;

        if (r_valid_q && r_ready) begin
            r_valid_d = 1'b0;
        end

        if (s1_adv) begin
            if (!s1_acc_q) begin
                // Standalone beat passes the frame state through untouched
                r_valid_d = 1'b1;
                r_d       = red;
                r_count_d = CW'(1);
            end else if (!s1_last_q) begin
                acc_d   = acc_q ^ red;
                cnt_d   = cnt_inc;
                state_d = ACCUM;
            end else begin
                r_valid_d = 1'b1;
                r_d       = acc_q ^ red;
                r_count_d = cnt_inc;
                acc_d     = '0;
                cnt_d     = '0;
                state_d   = IDLE;
            end
        end

        if (p_ready) begin
            s1_valid_d = p_valid;
            if (p_valid) begin
                s1_p_d    = p;
                s1_last_d = p_last;
                s1_acc_d  = acc_en;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_p_q     <= '0;
            s1_last_q  <= 1'b0;
            s1_acc_q   <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= IDLE;
            r_valid_q  <= 1'b0;
            r_q        <= '0;
            r_count_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_p_q     <= s1_p_d;
            s1_last_q  <= s1_last_d;
            s1_acc_q   <= s1_acc_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            r_valid_q  <= r_valid_d;
            r_q        <= r_d;
            r_count_q  <= r_count_d;
        end
    end

    assign r       = r_q;
    assign r_count = r_count_q;
    assign r_valid = r_valid_q;

    // s1_emit documents which S1 beats load O; kept for readability of s1_adv
    logic unused_ok;
    assign unused_ok = s1_emit;

endmodule

// File: tb/tb_gf8_reduce_acc.sv
// tb_gf8_reduce_acc: directed-vector bench for gf8_reduce_acc with
// hand-computed GF(2^8) results (POLY = 0x11B).
module tb_gf8_reduce_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] p = '0;
    logic        p_valid = 1'b0;
    logic        p_ready;
    logic        p_last = 1'b0;
    logic        acc_en = 1'b0;
    logic [7:0]  r;
    logic [7:0]  r_count;
    logic        r_valid;
    logic        r_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] q_r[$];
    logic [7:0] q_cnt[$];
    int         q_cyc[$];

    gf8_reduce_acc #(.POLY(9'h11B)) dut (
        .clk     (clk),
        .rst     (rst),
        .p       (p),
        .p_valid (p_valid),
        .p_ready (p_ready),
        .p_last  (p_last),
        .acc_en  (acc_en),
        .r       (r),
        .r_count (r_count),
        .r_valid (r_valid),
        .r_ready (r_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Collect every completed output transfer with the cycle it was seen in
    always @(negedge clk) begin
        if (r_valid && r_ready) begin
            q_r.push_back(r);
            q_cnt.push_back(r_count);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [14:0] pv, input logic a, input logic l, output int acc_cyc);
        int waited;
        waited = 0;
        @(negedge clk);
        p = pv; acc_en = a; p_last = l; p_valid = 1'b1;
        while (!p_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!p_ready) begin
            check_eq("send_timeout", 32'(p_ready), 32'd1);
            p_valid = 1'b0;
            acc_cyc = -1;
        end else begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            p_valid = 1'b0;
        end
    endtask

    task automatic expect_result(input string tag, input logic [7:0] er, input logic [7:0] ec,
                                 output int ocyc);
        int waited;
        waited = 0;
        while (q_r.size() == 0 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        check_eq({tag, "_avail"}, 32'(q_r.size() != 0), 32'd1);
        ocyc = -1;
        if (q_r.size() != 0) begin
            check_eq({tag, "_r"}, 32'(q_r.pop_front()), 32'(er));
            check_eq({tag, "_cnt"}, 32'(q_cnt.pop_front()), 32'(ec));
            ocyc = q_cyc.pop_front();
        end
    endtask

    initial begin
        int ac, oc, ac0, oc0;
        logic [14:0] vec_p[4];
        logic [7:0]  vec_r[4];
        vec_p[0] = 15'h0100; vec_r[0] = 8'h1B;
        vec_p[1] = 15'h4000; vec_r[1] = 8'h9A;
        vec_p[2] = 15'h00FF; vec_r[2] = 8'hFF;
        vec_p[3] = 15'h0000; vec_r[3] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_r_valid", 32'(r_valid), 32'd0);
        check_eq("rst_r", 32'(r), 32'd0);
        check_eq("rst_r_count", 32'(r_count), 32'd0);
        check_eq("rst_p_ready", 32'(p_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        r_ready = 1'b1;
        #1;
        check_eq("post_rst_p_ready", 32'(p_ready), 32'd1);

        // Single beat and two-cycle latency
        send(15'h2B79, 1'b0, 1'b0, ac);
        expect_result("single", 8'hC1, 8'd1, oc);
        check_eq("single_latency", 32'(oc - ac), 32'd1);

        // Boundary values back-to-back, no gaps on either side
        ac0 = 0; oc0 = 0;
        for (int i = 0; i < 4; i++) begin
            send(vec_p[i], 1'b0, 1'b0, ac);
            if (i == 0) ac0 = ac;
            else check_eq($sformatf("b2b_accept_%0d", i), 32'(ac - ac0), 32'(i));
        end
        for (int i = 0; i < 4; i++) begin
            expect_result($sformatf("bnd_%0d", i), vec_r[i], 8'd1, oc);
            if (i == 0) oc0 = oc;
            else check_eq($sformatf("b2b_out_%0d", i), 32'(oc - oc0), 32'(i));
        end

        // Three-term frame yields exactly one result
        send(15'h2B79, 1'b1, 1'b0, ac);
        send(15'h0100, 1'b1, 1'b0, ac);
        send(15'h00FF, 1'b1, 1'b1, ac);
        repeat (5) @(negedge clk);
        check_eq("frame_one_result", 32'(q_r.size()), 32'd1);
        expect_result("frame", 8'h25, 8'd3, oc);

        // Standalone beat interleaved inside an open frame
        send(15'h0100, 1'b1, 1'b0, ac);
        send(15'h4000, 1'b0, 1'b0, ac);
        send(15'h00FF, 1'b1, 1'b1, ac);
        expect_result("ilv_a", 8'h9A, 8'd1, oc);
        expect_result("ilv_b", 8'hE4, 8'd2, oc);

        // Backpressure: O holds first, S1 holds second, third waits
        @(posedge clk); #1;
        r_ready = 1'b0;
        send(15'h0100, 1'b0, 1'b0, ac);
        send(15'h4000, 1'b0, 1'b0, ac);
        @(negedge clk);
        p = 15'h2B79; acc_en = 1'b0; p_last = 1'b0; p_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("bp_p_ready_%0d", i), 32'(p_ready), 32'd0);
            check_eq($sformatf("bp_r_%0d", i), 32'(r), 32'h1B);
            check_eq($sformatf("bp_rv_%0d", i), 32'(r_valid), 32'd1);
            @(negedge clk);
        end
        check_eq("bp_r_count", 32'(r_count), 32'd1);
        check_eq("bp_no_output", 32'(q_r.size()), 32'd0);
        @(posedge clk); #1;
        r_ready = 1'b1;
        @(posedge clk); #1;
        p_valid = 1'b0;
        expect_result("bp_0", 8'h1B, 8'd1, oc);
        expect_result("bp_1", 8'h9A, 8'd1, oc);
        expect_result("bp_2", 8'hC1, 8'd1, oc);

        // 300-term frame of x^0: even count XORs to zero, count saturates
        for (int i = 0; i < 300; i++) begin
            send(15'h0001, 1'b1, (i == 299), ac);
        end
        expect_result("sat", 8'h00, 8'hFF, oc);

        // Reset with a partial sum held and a pending stalled output
        @(posedge clk); #1;
        r_ready = 1'b0;
        send(15'h0100, 1'b1, 1'b0, ac);
        send(15'h0100, 1'b1, 1'b0, ac);
        send(15'h4000, 1'b0, 1'b0, ac);
        repeat (2) @(posedge clk);
        #1;
        check_eq("pre_rst_r_valid", 32'(r_valid), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_r_valid", 32'(r_valid), 32'd0);
        check_eq("mid_rst_r", 32'(r), 32'd0);
        check_eq("mid_rst_r_count", 32'(r_count), 32'd0);
        check_eq("mid_rst_p_ready", 32'(p_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        r_ready = 1'b1;
        #1;
        check_eq("after_rst_p_ready", 32'(p_ready), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("after_rst_no_output", 32'(q_r.size()), 32'd0);
        send(15'h0100, 1'b1, 1'b1, ac);
        expect_result("after_rst_frame", 8'h1B, 8'd1, oc);

        repeat (3) @(negedge clk);
        check_eq("final_no_extra", 32'(q_r.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gf8_reduce_acc.md
GF8_REDUCE_ACC -- requirements
Module: gf8_reduce_acc

Interface
REQ-001 Parameter POLY, default 9'h11B, irreducible GF(2^8) modulus; bit 8 SHALL be 1.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 p  in  15  carry-less 8x8 product from the upstream multiplier, coefficient of x^i in bit i.
REQ-005 p_valid  in  1  p, p_last and acc_en are valid this cycle.
REQ-006 p_ready  out  1  block accepts a beat this cycle.
REQ-007 p_last  in  1  final term of an accumulation frame; ignored when acc_en=0.
REQ-008 acc_en  in  1  beat joins the running GF(2^8) sum instead of being emitted alone.
REQ-009 r  out  8  reduced result, p mod POLY or the XOR-sum of reduced terms.
REQ-010 r_count  out  8  number of terms folded into r, saturating at 255.
REQ-011 r_valid  out  1  r and r_count are valid.
REQ-012 r_ready  in  1  downstream accepts r this cycle.

Function
REQ-013 A beat transfers when p_valid=1 and p_ready=1; a result transfers when r_valid=1 and r_ready=1.
REQ-014 Pipeline: input stage S1 (p, last, acc, valid) followed by output register O; the accumulator register acc[7:0], term counter cnt[7:0] and FSM sit between S1 and O.
REQ-015 The reduction SHALL be combinational from S1: it clears bits 14..8 highest-first, XORing POLY shifted left by (i-8) for each set bit i.
REQ-016 Output slot free: ofree = !r_valid || r_ready.
REQ-017 S1 advances when it holds a beat and one of these holds: (acc=1 and last=0), or ofree=1.
REQ-018 p_ready = !S1.valid || S1 advances; it SHALL have no combinational path from p_valid.
REQ-019 FSM states: IDLE (acc=0, cnt=0) and ACCUM (a partial sum is held).
REQ-020 Non-acc beat advancing: O loads r=red and r_count=1; acc, cnt and the state are unchanged, including in ACCUM.
REQ-021 Acc beat with last=0 advancing: acc <= acc^red, cnt <= sat(cnt+1), state goes to ACCUM; O is untouched.
REQ-022 Acc beat with last=1 advancing: O loads r=acc^red and r_count=sat(cnt+1); acc and cnt clear and the state goes to IDLE. A one-beat frame SHALL give r_count=1.
REQ-023 Saturation: cnt and r_count SHALL hold at 255 and never wrap.
REQ-024 Latency: with r_ready held high, a non-acc or last beat accepted in cycle N SHALL appear on r in cycle N+2.
REQ-025 Throughput: with r_ready held high, the block SHALL accept one beat per cycle without bubbles.
REQ-026 Backpressure: when O is full and r_ready=0, O holds r and r_count stable. At most one further output-producing beat waits in S1, and p_ready falls.
REQ-027 Simultaneous events: O unloading and reloading in the same cycle SHALL lose nothing and duplicate nothing. An acc beat with last=0 SHALL advance even while O is stalled.

Reset
REQ-028 While rst=1: r_valid=0, r=0, r_count=0, p_ready=0, S1.valid=0, acc=0, cnt=0, state=IDLE.
REQ-029 p_ready SHALL become 1 in the first cycle after rst deasserts.
REQ-030 Reset mid-frame SHALL discard the partial sum and any pending outputs; the next frame starts from a zero sum.

Verification
REQ-031 Single beat, POLY=11B: p=0x2B79, acc_en=0, r_ready=1 -> r=0xC1, r_count=1, two cycles after acceptance.
REQ-032 Boundary values: p=0x0100 -> 0x1B; p=0x4000 -> 0x9A; p=0x00FF -> 0xFF; p=0x0000 -> 0x00. Beats issued back-to-back SHALL produce results in order with no gaps.
REQ-033 Frame: 0x2B79 (acc), 0x0100 (acc), 0x00FF (acc, last) -> exactly one result, r=0x25, r_count=3. No r_valid is produced for the first two beats.
REQ-034 Interleave: in ACCUM after one term 0x0100, a non-acc beat 0x4000, then last 0x00FF -> results r=0x9A/count 1, then r=0xE4/count 2.
REQ-035 Backpressure: r_ready=0 with three non-acc beats offered -> O holds the first result, S1 holds the second, p_ready=0. Releasing r_ready delivers all three in order.
REQ-036 Saturation and reset: a 300-term acc frame -> r_count=255. rst pulsed mid-frame -> outputs clear, and a following one-beat frame 0x0100 gives r=0x1B, r_count=1.
